// File: rtl/ex_ma_pkg.sv
// Shared types and constants for the EX->MA boundary of the SimpleRISC core.
// Used by the stage register top and its flags/branch sub-unit.
package ex_ma_pkg;

  localparam int XLEN  = 32;
  localparam int RAW   = 4;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic isWb;
    logic isLd;
    logic isSt;
    logic isCmp;
    logic isBeq;
    logic isBgt;
    logic isUBranch;
    logic isRet;
  } ex_ctrl_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] op2;
    logic [RAW-1:0]  rd;
    logic            isWb;
    logic            isLd;
    logic            isSt;
  } ma_bundle_t;

  typedef enum logic {
    IDLE = 1'b0,
    KILL = 1'b1
  } kill_state_e;

  // Branch condition, evaluated against the architectural (registered) flags only.
  function automatic logic branch_cond(input ex_ctrl_t c, input logic gt, input logic eq);
    return c.isUBranch | c.isRet | (c.isBeq & eq) | (c.isBgt & gt);
  endfunction

endpackage

// File: rtl/ex_ma_stage_reg_flags_branch_unit.sv
// Architectural gt/eq flags register plus the EX-stage branch decision and target mux.
// The decision uses the registered flags, so a cmp only affects branches after it advances.
module flags_branch_unit
  import ex_ma_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            adv,
  input  ex_ctrl_t        ctrl,
  input  logic            ex_gt,
  input  logic            ex_eq,
  input  logic [XLEN-1:0] ex_op1,
  input  logic [XLEN-1:0] ex_branchTarget,
  output logic            flags_gt,
  output logic            flags_eq,
  output logic            isBranchTaken,
  output logic [XLEN-1:0] branchPC
);

  logic            r_gt;
  logic            r_eq;
  logic            w_taken;
  logic [XLEN-1:0] w_branch_pc;

  // Flags register: only an advancing cmp writes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gt <= 1'b0;
      r_eq <= 1'b0;
    end else if (adv && ctrl.isCmp) begin
      r_gt <= ex_gt;
      r_eq <= ex_eq;
    end else begin
      r_gt <= r_gt;
      r_eq <= r_eq;
    end
  end

  // Branch decision and redirect target; target reads as zero when not taken.
  always_comb begin
    w_taken     = adv & branch_cond(ctrl, r_gt, r_eq);
    w_branch_pc = {XLEN{1'b0}};
    if (w_taken) begin
      if (ctrl.isRet) begin
        w_branch_pc = ex_op1;
      end else begin
        w_branch_pc = ex_branchTarget;
      end
    end else begin
      w_branch_pc = {XLEN{1'b0}};
    end
  end

  assign flags_gt      = r_gt;
  assign flags_eq      = r_eq;
  assign isBranchTaken = w_taken;
  assign branchPC      = w_branch_pc;

endmodule

// File: rtl/ex_ma_stage_reg.sv
// EX->MA pipeline register: latches ALU result and controls into MA, owns the wrong-path
// kill pulse FSM and the retired-instruction counter; flags/branch logic lives in a sub-unit.
module ex_ma_stage_reg
  import ex_ma_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_aluResult,
  input  logic             ex_gt,
  input  logic             ex_eq,
  input  logic [XLEN-1:0]  ex_op2,
  input  logic [XLEN-1:0]  ex_branchTarget,
  input  logic [XLEN-1:0]  ex_op1,
  input  logic [RAW-1:0]   ex_rd,
  input  logic             ex_isCmp,
  input  logic             ex_isBeq,
  input  logic             ex_isBgt,
  input  logic             ex_isUBranch,
  input  logic             ex_isRet,
  input  logic             ex_isWb,
  input  logic             ex_isLd,
  input  logic             ex_isSt,
  output logic             ma_valid,
  output logic [XLEN-1:0]  ma_pc,
  output logic [XLEN-1:0]  ma_aluResult,
  output logic [XLEN-1:0]  ma_op2,
  output logic [RAW-1:0]   ma_rd,
  output logic             ma_isWb,
  output logic             ma_isLd,
  output logic             ma_isSt,
  output logic             flags_gt,
  output logic             flags_eq,
  output logic             isBranchTaken,
  output logic [XLEN-1:0]  branchPC,
  output logic             kill_younger,
  output logic [CNT_W-1:0] retired_cnt
);

  ex_ctrl_t         w_ctrl;
  ma_bundle_t       w_ex_bundle;
  ma_bundle_t       r_ma;
  kill_state_e      r_state;
  logic [CNT_W-1:0] r_retired_cnt;
  logic             w_adv;
  logic             w_taken;

  assign w_adv = ex_valid & ~stall_i & ~flush_i;

  assign w_ctrl = '{
    isWb:      ex_isWb,
    isLd:      ex_isLd,
    isSt:      ex_isSt,
    isCmp:     ex_isCmp,
    isBeq:     ex_isBeq,
    isBgt:     ex_isBgt,
    isUBranch: ex_isUBranch,
    isRet:     ex_isRet
  };

  assign w_ex_bundle = '{
    valid:     ex_valid,
    pc:        ex_pc,
    aluResult: ex_aluResult,
    op2:       ex_op2,
    rd:        ex_rd,
    isWb:      ex_isWb,
    isLd:      ex_isLd,
    isSt:      ex_isSt
  };

  flags_branch_unit u_flags_branch (
    .clk            (clk),
    .rst_n          (rst_n),
    .adv            (w_adv),
    .ctrl           (w_ctrl),
    .ex_gt          (ex_gt),
    .ex_eq          (ex_eq),
    .ex_op1         (ex_op1),
    .ex_branchTarget(ex_branchTarget),
    .flags_gt       (flags_gt),
    .flags_eq       (flags_eq),
    .isBranchTaken  (w_taken),
    .branchPC       (branchPC)
  );

  // MA latch: flush kills the entry (data fields keep their stale value), stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ma <= '0;
    end else if (flush_i) begin
      r_ma.valid <= 1'b0;
      r_ma.isWb  <= 1'b0;
      r_ma.isLd  <= 1'b0;
      r_ma.isSt  <= 1'b0;
    end else if (stall_i) begin
      r_ma <= r_ma;
    end else begin
      r_ma <= w_ex_bundle;
    end
  end

  // Wrong-path kill FSM: one KILL cycle per taken branch, re-armed by back-to-back branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_taken) begin
            r_state <= KILL;
          end else begin
            r_state <= IDLE;
          end
        end
        KILL: begin
          if (flush_i) begin
            r_state <= IDLE;
          end else if (w_taken) begin
            r_state <= KILL;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Retired counter: wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired_cnt <= {CNT_W{1'b0}};
    end else if (w_adv) begin
      r_retired_cnt <= r_retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_retired_cnt <= r_retired_cnt;
    end
  end

  assign ma_valid      = r_ma.valid;
  assign ma_pc         = r_ma.pc;
  assign ma_aluResult  = r_ma.aluResult;
  assign ma_op2        = r_ma.op2;
  assign ma_rd         = r_ma.rd;
  assign ma_isWb       = r_ma.isWb;
  assign ma_isLd       = r_ma.isLd;
  assign ma_isSt       = r_ma.isSt;
  assign isBranchTaken = w_taken;
  assign kill_younger  = (r_state == KILL);
  assign retired_cnt   = r_retired_cnt;

endmodule

// File: tb/tb_ex_ma_stage_reg.sv
// Self-checking bench for ex_ma_stage_reg: directed scenarios plus randomized traffic,
// compared against a behavioural model of the stage kept in the bench.
module tb_ex_ma_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, ex_valid;
  logic [31:0] ex_pc, ex_aluResult, ex_op2, ex_branchTarget, ex_op1;
  logic        ex_gt, ex_eq;
  logic [3:0]  ex_rd;
  logic        ex_isCmp, ex_isBeq, ex_isBgt, ex_isUBranch, ex_isRet, ex_isWb, ex_isLd, ex_isSt;
  logic        ma_valid, ma_isWb, ma_isLd, ma_isSt;
  logic [31:0] ma_pc, ma_aluResult, ma_op2, branchPC, retired_cnt;
  logic [3:0]  ma_rd;
  logic        flags_gt, flags_eq, isBranchTaken, kill_younger;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic        m_valid, m_isWb, m_isLd, m_isSt, m_gt, m_eq, m_kill;
  logic [31:0] m_pc, m_alu, m_op2, m_cnt;
  logic [3:0]  m_rd;

  always #5 clk = ~clk;

  ex_ma_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_aluResult(ex_aluResult), .ex_gt(ex_gt), .ex_eq(ex_eq), .ex_op2(ex_op2),
    .ex_branchTarget(ex_branchTarget), .ex_op1(ex_op1), .ex_rd(ex_rd),
    .ex_isCmp(ex_isCmp), .ex_isBeq(ex_isBeq), .ex_isBgt(ex_isBgt), .ex_isUBranch(ex_isUBranch),
    .ex_isRet(ex_isRet), .ex_isWb(ex_isWb), .ex_isLd(ex_isLd), .ex_isSt(ex_isSt),
    .ma_valid(ma_valid), .ma_pc(ma_pc), .ma_aluResult(ma_aluResult), .ma_op2(ma_op2),
    .ma_rd(ma_rd), .ma_isWb(ma_isWb), .ma_isLd(ma_isLd), .ma_isSt(ma_isSt),
    .flags_gt(flags_gt), .flags_eq(flags_eq), .isBranchTaken(isBranchTaken),
    .branchPC(branchPC), .kill_younger(kill_younger), .retired_cnt(retired_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_advances();
    return ex_valid && !stall_i && !flush_i;
  endfunction

  function automatic logic model_taken();
    if (!model_advances()) return 1'b0;
    return ex_isUBranch || ex_isRet || (ex_isBeq && m_eq) || (ex_isBgt && m_gt);
  endfunction

  function automatic logic [31:0] model_target();
    if (!model_taken()) return 32'h0;
    return ex_isRet ? ex_op1 : ex_branchTarget;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_isWb = 1'b0; m_isLd = 1'b0; m_isSt = 1'b0;
    m_gt = 1'b0; m_eq = 1'b0; m_kill = 1'b0;
    m_pc = 32'h0; m_alu = 32'h0; m_op2 = 32'h0; m_rd = 4'h0; m_cnt = 32'h0;
  endtask

  // One clock edge of the stage as described by its behavioural rules.
  task automatic model_edge();
    logic taken;
    logic adv;
    taken = model_taken();
    adv   = model_advances();
    if (flush_i) begin
      m_valid = 1'b0; m_isWb = 1'b0; m_isLd = 1'b0; m_isSt = 1'b0;
    end else if (!stall_i) begin
      m_valid = ex_valid; m_pc = ex_pc; m_alu = ex_aluResult; m_op2 = ex_op2; m_rd = ex_rd;
      m_isWb = ex_isWb; m_isLd = ex_isLd; m_isSt = ex_isSt;
    end
    if (adv && ex_isCmp) begin
      m_gt = ex_gt; m_eq = ex_eq;
    end
    m_kill = taken;
    if (adv) m_cnt = m_cnt + 32'd1;
  endtask

  task automatic check_regs();
    chk("ma_valid", {63'h0, ma_valid}, {63'h0, m_valid});
    chk("ma_isWb", {63'h0, ma_isWb}, {63'h0, m_isWb});
    chk("ma_isLd", {63'h0, ma_isLd}, {63'h0, m_isLd});
    chk("ma_isSt", {63'h0, ma_isSt}, {63'h0, m_isSt});
    if (m_valid) begin
      chk("ma_pc", {32'h0, ma_pc}, {32'h0, m_pc});
      chk("ma_aluResult", {32'h0, ma_aluResult}, {32'h0, m_alu});
      chk("ma_op2", {32'h0, ma_op2}, {32'h0, m_op2});
      chk("ma_rd", {60'h0, ma_rd}, {60'h0, m_rd});
    end
    chk("flags_gt", {63'h0, flags_gt}, {63'h0, m_gt});
    chk("flags_eq", {63'h0, flags_eq}, {63'h0, m_eq});
    chk("kill_younger", {63'h0, kill_younger}, {63'h0, m_kill});
    chk("retired_cnt", {32'h0, retired_cnt}, {32'h0, m_cnt});
  endtask

  task automatic check_comb();
    chk("isBranchTaken", {63'h0, isBranchTaken}, {63'h0, model_taken()});
    chk("branchPC", {32'h0, branchPC}, {32'h0, model_target()});
  endtask

  // Inputs are set at a falling edge; this completes the cycle and checks both halves.
  task automatic cycle();
    #1 check_comb();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_regs();
  endtask

  task automatic set_idle();
    stall_i = 1'b0; flush_i = 1'b0; ex_valid = 1'b0;
    ex_pc = 32'h0; ex_aluResult = 32'h0; ex_op2 = 32'h0; ex_branchTarget = 32'h0; ex_op1 = 32'h0;
    ex_gt = 1'b0; ex_eq = 1'b0; ex_rd = 4'h0;
    ex_isCmp = 1'b0; ex_isBeq = 1'b0; ex_isBgt = 1'b0; ex_isUBranch = 1'b0; ex_isRet = 1'b0;
    ex_isWb = 1'b0; ex_isLd = 1'b0; ex_isSt = 1'b0;
  endtask

  task automatic set_random();
    stall_i = ($urandom_range(0, 4) == 0);
    flush_i = ($urandom_range(0, 9) == 0);
    ex_valid = ($urandom_range(0, 4) != 0);
    ex_pc = $urandom(); ex_aluResult = $urandom(); ex_op2 = $urandom();
    ex_branchTarget = $urandom(); ex_op1 = $urandom();
    ex_gt = 1'($urandom()); ex_eq = 1'($urandom()); ex_rd = 4'($urandom());
    ex_isCmp = ($urandom_range(0, 3) == 0); ex_isBeq = ($urandom_range(0, 4) == 0);
    ex_isBgt = ($urandom_range(0, 4) == 0); ex_isUBranch = ($urandom_range(0, 9) == 0);
    ex_isRet = ($urandom_range(0, 11) == 0);
    ex_isWb = 1'($urandom()); ex_isLd = 1'($urandom()); ex_isSt = 1'($urandom());
  endtask

  initial begin
    set_idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_regs();
    rst_n = 1'b1;

    // Five plain advances so the stage is full and the counter is non-zero.
    for (int i = 0; i < 5; i++) begin
      set_idle(); ex_valid = 1'b1; ex_isWb = 1'b1; ex_pc = 32'h100 + 32'(i * 4);
      ex_aluResult = $urandom(); ex_rd = 4'($urandom());
      cycle();
    end
    chk("pre_reset_cnt", {32'h0, retired_cnt}, 64'd5);
    chk("pre_reset_valid", {63'h0, ma_valid}, 64'd1);

    // 1: asynchronous reset between edges
    set_idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'h0, ma_valid}, 64'd0);
    chk("async_rst_cnt", {32'h0, retired_cnt}, 64'd0);
    chk("async_rst_isWb", {63'h0, ma_isWb}, 64'd0);
    chk("async_rst_pc", {32'h0, ma_pc}, 64'd0);
    chk("async_rst_flags", {62'h0, flags_gt, flags_eq}, 64'd0);
    chk("async_rst_kill", {63'h0, kill_younger}, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // 2: cmp gt, then bgt to 0x40
    set_idle(); ex_valid = 1'b1; ex_isCmp = 1'b1; ex_gt = 1'b1; ex_eq = 1'b0;
    cycle();
    chk("t2_flags_gt", {63'h0, flags_gt}, 64'd1);
    set_idle(); ex_valid = 1'b1; ex_isBgt = 1'b1; ex_branchTarget = 32'h40;
    #1;
    chk("t2_taken", {63'h0, isBranchTaken}, 64'd1);
    chk("t2_branchPC", {32'h0, branchPC}, 64'h40);
    cycle();
    chk("t2_kill_on", {63'h0, kill_younger}, 64'd1);
    set_idle();
    cycle();
    chk("t2_kill_off", {63'h0, kill_younger}, 64'd0);

    // 3: stalled cmp must not write flags; released it does; beq then taken
    set_idle(); ex_valid = 1'b1; ex_isCmp = 1'b1; ex_eq = 1'b1; stall_i = 1'b1;
    cycle();
    chk("t3_stalled_eq", {63'h0, flags_eq}, 64'd0);
    stall_i = 1'b0;
    cycle();
    chk("t3_released_eq", {63'h0, flags_eq}, 64'd1);
    set_idle(); ex_valid = 1'b1; ex_isBeq = 1'b1; ex_branchTarget = 32'h80;
    #1;
    chk("t3_beq_taken", {63'h0, isBranchTaken}, 64'd1);
    cycle();

    // 4: stall and flush together
    set_idle(); ex_valid = 1'b1; ex_isWb = 1'b1; stall_i = 1'b1; flush_i = 1'b1;
    cycle();
    chk("t4_valid", {63'h0, ma_valid}, 64'd0);
    chk("t4_isWb", {63'h0, ma_isWb}, 64'd0);
    chk("t4_cnt", {32'h0, retired_cnt}, 64'd4);

    // 5: ret target, then beq with eq cleared is not taken
    set_idle(); ex_valid = 1'b1; ex_isRet = 1'b1; ex_op1 = 32'h1234; ex_branchTarget = 32'h99;
    #1;
    chk("t5_ret_taken", {63'h0, isBranchTaken}, 64'd1);
    chk("t5_ret_pc", {32'h0, branchPC}, 64'h1234);
    cycle();
    set_idle(); ex_valid = 1'b1; ex_isCmp = 1'b1; ex_gt = 1'b0; ex_eq = 1'b0;
    cycle();
    set_idle(); ex_valid = 1'b1; ex_isBeq = 1'b1; ex_branchTarget = 32'h200;
    #1;
    chk("t5_beq_not_taken", {63'h0, isBranchTaken}, 64'd0);
    chk("t5_beq_pc_zero", {32'h0, branchPC}, 64'd0);
    cycle();
    chk("t5_kill_stays_0", {63'h0, kill_younger}, 64'd0);

    // 6: counter wrap
    set_idle();
    force dut.r_retired_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_retired_cnt;
    m_cnt = 32'hFFFF_FFFF;
    chk("t6_preload", {32'h0, retired_cnt}, 64'hFFFF_FFFF);
    ex_valid = 1'b1;
    cycle();
    chk("t6_wrap", {32'h0, retired_cnt}, 64'd0);
    chk("t6_no_x", {63'h0, $isunknown(retired_cnt)}, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_random();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
